acc_store_buffer: RTL

//  Write path from ACC back into DATA_MEM; it covers the reverse direction of the memory-to-ACC operand select.

---
 rtl/acc_store_buffer_pkg.sv | 10 +
 rtl/store_buf_fifo.sv | 66 ++++++
 rtl/acc_store_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/acc_store_buffer_pkg.sv
// Shared widths and FSM encoding for the ACC -> DATA_MEM store buffer.
package bip_pkg;
    localparam int DEF_LEN_DATA = 16;
    localparam int DEF_LEN_ADDR = 11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/store_buf_fifo.sv
// Circular addr/data register file for posted stores, with a coalescing write port
// that rewrites the youngest entry in place instead of allocating a new one.
module store_buf_fifo
    import bip_pkg::*;
#(
    parameter int len_data = DEF_LEN_DATA,
    parameter int len_addr = DEF_LEN_ADDR,
    parameter int DEPTH    = 2,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               coalesce,
    input  logic [len_addr-1:0]                wr_addr,
    input  logic [len_data-1:0]                wr_data,
    output logic [PW-1:0]                      head_ptr,
    output logic [PW-1:0]                      tail_ptr,
    output logic [CW-1:0]                      count,
    output logic [DEPTH-1:0][len_addr-1:0]     ent_addr,
    output logic [DEPTH-1:0][len_data-1:0]     ent_data
);
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          alloc;
    logic [PW-1:0] wr_idx;

    logic [len_addr-1:0] addr_reg [DEPTH];
    logic [len_data-1:0] data_reg [DEPTH];

    // A coalescing push targets the youngest entry (tail-1) and allocates nothing.
    assign alloc      = push & ~coalesce;
    assign wr_idx     = coalesce ? (tail_reg - PW'(1)) : tail_reg;
    assign count_next = count_reg + CW'(alloc) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PW'(pop);
            tail_reg  <= tail_reg + PW'(alloc);
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_idx == PW'(gi))) begin
                    addr_reg[gi] <= wr_addr;
                    data_reg[gi] <= wr_data;
                end
            end
            assign ent_addr[gi] = addr_reg[gi];
            assign ent_data[gi] = data_reg[gi];
        end
    endgenerate

    assign head_ptr = head_reg;
    assign tail_ptr = tail_reg;
    assign count    = count_reg;
endmodule

// File: rtl/acc_store_buffer.sv
// Posted-store buffer between ACC and DATA_MEM: drain, store stall, load forwarding
// and a flush handshake for the debug unit.
module acc_store_buffer
    import bip_pkg::*;
#(
    parameter int len_data = DEF_LEN_DATA,
    parameter int len_addr = DEF_LEN_ADDR,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_ram,
    input  logic [len_addr-1:0] wr_addr,
    input  logic [len_data-1:0] wr_data,
    output logic                stall,
    input  logic                rd_ram,
    input  logic [len_addr-1:0] rd_addr,
    output logic                fwd_hit,
    output logic [len_data-1:0] fwd_data,
    output logic                mem_we,
    output logic [len_addr-1:0] mem_addr,
    output logic [len_data-1:0] mem_din,
    input  logic                mem_ready,
    input  logic                flush_req,
    output logic                flush_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                  head_ptr, tail_ptr, last_ptr;
    logic [CW-1:0]                  count;
    logic [DEPTH-1:0][len_addr-1:0] ent_addr;
    logic [DEPTH-1:0][len_data-1:0] ent_data;
    logic                           push, pop, coalesce, full;
    state_t                         state_reg;
    logic                           flush_done_reg;

    assign mem_we   = (count != '0);
    assign mem_addr = ent_addr[head_ptr];
    assign mem_din  = ent_data[head_ptr];
    assign pop      = mem_we & mem_ready;

    assign full     = (count == CW'(DEPTH));
    assign stall    = wr_ram & ((full & ~pop) | (state_reg == ST_FLUSH));
    assign push     = wr_ram & ~stall;

    // Never coalesce into an entry that is leaving this cycle.
    assign last_ptr = tail_ptr - PW'(1);
    assign coalesce = push & (count != '0) & (wr_addr == ent_addr[last_ptr])
                    & ((count > CW'(1)) | ~pop);

    store_buf_fifo #(
        .len_data (len_data),
        .len_addr (len_addr),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .coalesce (coalesce),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .count    (count),
        .ent_addr (ent_addr),
        .ent_data (ent_data)
    );

    // match[k] refers to the k-th oldest valid entry, so the highest k wins.
    logic [DEPTH-1:0] match;
    logic [PW-1:0]    age_idx [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign age_idx[gi] = head_ptr + PW'(gi);
            assign match[gi]   = rd_ram & (CW'(gi) < count)
                               & (ent_addr[age_idx[gi]] == rd_addr);
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[age_idx[k]];
            end
        end
    end

    // An empty buffer with no store entering completes a flush request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            flush_done_reg <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (flush_req) begin
                    if (count == '0 && !push)
                        flush_done_reg <= 1'b1;
                    else
                        state_reg <= ST_FLUSH;
                end
            end else if (count == '0) begin
                state_reg      <= ST_IDLE;
                flush_done_reg <= 1'b1;
            end
        end
    end

    assign flush_done = flush_done_reg;
endmodule
